// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the byte-serial memory controller.
//   state_e      controller FSM states
//   LenIllegal   data_len_in code that is promoted to a word access
//   LenWord      bytes-minus-one code for a 4-byte access
//   IoAddrHi     a[17:16] value that selects the UART/IO window
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StInstRead,
        StDataRead,
        StDataWrite
    } state_e;

    localparam logic [1:0] LenIllegal = 2'd2;
    localparam logic [1:0] LenWord    = 2'd3;
    localparam logic [1:0] IoAddrHi   = 2'b11;

    // Length code 2 has no byte-lane meaning, so it is served as a full word.
    function automatic logic [1:0] eff_len(input logic [1:0] len);
        return (len == LenIllegal) ? LenWord : len;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates icache fetches and LSB loads/stores onto a byte-wide synchronous RAM.
// Ports:
//   clk_in, rst_in                       clock, asynchronous active-high reset
//   inst_read_in, inst_address_in        fetch request (held until served)
//   inst_busy_out, inst_enable_out,
//   inst_data_out                        fetch path busy / one-cycle done / fetched word
//   data_read_in, data_write_in,
//   data_address_in, data_len_in,
//   data_wdata_in                        load/store request, length (bytes-1), store data
//   data_busy_out, data_enable_out,
//   data_rdata_out                       data path busy / one-cycle done / zero-extended load
//   jump_clear_in                        branch flush, aborts an in-flight fetch
//   io_buffer_full                       UART buffer full
//   mem_din, mem_dout, mem_a, mem_wr     RAM read byte (1-cycle latency), write byte, address,
//                                        write strobe
// Build option: MEMCTRL_IO_STALL_EN holds store byte cycles into the IO window while
// io_buffer_full is high; without it io_buffer_full is ignored.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        inst_read_in,
    input  logic [31:0] inst_address_in,
    output logic        inst_busy_out,
    output logic        inst_enable_out,
    output logic [31:0] inst_data_out,
    input  logic        data_read_in,
    input  logic        data_write_in,
    input  logic [31:0] data_address_in,
    input  logic [1:0]  data_len_in,
    input  logic [31:0] data_wdata_in,
    output logic        data_busy_out,
    output logic        data_enable_out,
    output logic [31:0] data_rdata_out,
    input  logic        jump_clear_in,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  len_q, len_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic        inst_en_q, inst_en_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic        data_en_q, data_en_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] cur_addr;
    logic [1:0]  rd_idx;
    logic        stall;

    assign cur_addr = addr_q + 32'(cnt_q);
    // The byte on mem_din belongs to the address driven one cycle earlier.
    assign rd_idx   = cnt_q[1:0] - 2'd1;

`ifdef MEMCTRL_IO_STALL_EN
    assign stall = io_buffer_full && (cur_addr[17:16] == IoAddrHi);
`else
    logic unused_io;
    assign unused_io = io_buffer_full & (cur_addr[17:16] == IoAddrHi);
    assign stall     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        inst_en_d   = 1'b0;
        inst_data_d = inst_data_q;
        data_en_d   = 1'b0;
        rdata_d     = rdata_q;
        mem_a       = 32'd0;
        mem_dout    = 8'd0;
        mem_wr      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // The done-pulse cycle never accepts, so a requester still holding its
                // request while it sees the pulse is not served twice.
                if (!inst_en_q && !data_en_q) begin
                    if (data_read_in || data_write_in) begin
                        state_d = data_write_in ? StDataWrite : StDataRead;
                        addr_d  = data_address_in;
                        len_d   = eff_len(data_len_in);
                        wdata_d = data_wdata_in;
                        cnt_d   = 3'd0;
                        buf_d   = 32'd0;
                    end else if (inst_read_in && !jump_clear_in) begin
                        state_d = StInstRead;
                        addr_d  = inst_address_in;
                        len_d   = LenWord;
                        cnt_d   = 3'd0;
                        buf_d   = 32'd0;
                    end
                end
            end

            StInstRead, StDataRead: begin
                // Address phase for cnt 0..len, then one extra cycle to capture the last byte.
                if (cnt_q <= {1'b0, len_q}) begin
                    mem_a = cur_addr;
                end
                if (cnt_q != 3'd0) begin
                    buf_d[{rd_idx, 3'b000} +: 8] = mem_din;
                end
                if (state_q == StInstRead && jump_clear_in) begin
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                end else if (cnt_q == ({1'b0, len_q} + 3'd1)) begin
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                    if (state_q == StInstRead) begin
                        inst_en_d   = 1'b1;
                        inst_data_d = buf_d;
                    end else begin
                        data_en_d = 1'b1;
                        rdata_d   = buf_d;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            StDataWrite: begin
                mem_a    = cur_addr;
                mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                if (!stall) begin
                    mem_wr = 1'b1;
                    if (cnt_q == {1'b0, len_q}) begin
                        state_d   = StIdle;
                        cnt_d     = 3'd0;
                        data_en_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            addr_q      <= 32'd0;
            len_q       <= 2'd0;
            wdata_q     <= 32'd0;
            buf_q       <= 32'd0;
            inst_en_q   <= 1'b0;
            inst_data_q <= 32'd0;
            data_en_q   <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            inst_en_q   <= inst_en_d;
            inst_data_q <= inst_data_d;
            data_en_q   <= data_en_d;
            rdata_q     <= rdata_d;
        end
    end

    assign inst_busy_out   = (state_q == StInstRead);
    assign data_busy_out   = (state_q == StDataRead) || (state_q == StDataWrite);
    assign inst_enable_out = inst_en_q;
    assign inst_data_out   = inst_data_q;
    assign data_enable_out = data_en_q;
    assign data_rdata_out  = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl with a byte RAM, a transaction-level
// reference memory, a constant vector table, random traffic and hand-written corner cases.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        inst_read_in = 1'b0;
    logic [31:0] inst_address_in = 32'd0;
    logic        inst_busy_out, inst_enable_out;
    logic [31:0] inst_data_out;
    logic        data_read_in = 1'b0, data_write_in = 1'b0;
    logic [31:0] data_address_in = 32'd0;
    logic [1:0]  data_len_in = 2'd0;
    logic [31:0] data_wdata_in = 32'd0;
    logic        data_busy_out, data_enable_out;
    logic [31:0] data_rdata_out;
    logic        jump_clear_in = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    mem_ctrl u_dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .inst_read_in    (inst_read_in),
        .inst_address_in (inst_address_in),
        .inst_busy_out   (inst_busy_out),
        .inst_enable_out (inst_enable_out),
        .inst_data_out   (inst_data_out),
        .data_read_in    (data_read_in),
        .data_write_in   (data_write_in),
        .data_address_in (data_address_in),
        .data_len_in     (data_len_in),
        .data_wdata_in   (data_wdata_in),
        .data_busy_out   (data_busy_out),
        .data_enable_out (data_enable_out),
        .data_rdata_out  (data_rdata_out),
        .jump_clear_in   (jump_clear_in),
        .io_buffer_full  (io_buffer_full),
        .mem_din         (mem_din),
        .mem_dout        (mem_dout),
        .mem_a           (mem_a),
        .mem_wr          (mem_wr)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          kind;     // 0 fetch, 1 load, 2 store
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_lat;  // cycles from the sampling edge to the done pulse
    } vec_t;

    logic [7:0]  ram     [0:262143];
    logic [7:0]  ref_mem [0:262143];
    logic [39:0] wlog [$];
    int          wr_outside = 0;
    int          inst_pulses = 0, data_pulses = 0;
    int          checks = 0, failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input int kind, input logic [1:0] len);
        if (kind == 0 || len[1]) return 4;
        return (len == 2'd1) ? 2 : 1;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input int n);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) begin
            logic [31:0] a = addr + 32'(i);
            v = v | (32'(ref_mem[a[17:0]]) << (8 * i));
        end
        return v;
    endfunction

    task automatic model_store(input logic [31:0] addr, input int n, input logic [31:0] wd);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a = addr + 32'(i);
            ref_mem[a[17:0]] = wd[8*i +: 8];
        end
    endtask

    // Compares the captured RAM write cycles against the bytes the store should produce.
    task automatic check_wlog(input string name, input logic [31:0] addr, input int n,
                              input logic [31:0] wd);
        int bad = 0;
        check({name, "_count"}, 32'(wlog.size()), 32'(n));
        for (int i = 0; i < n && i < wlog.size(); i++) begin
            if (wlog[i] !== {addr + 32'(i), wd[8*i +: 8]}) bad++;
        end
        check({name, "_bytes"}, 32'(bad), 32'd0);
    endtask

    // Called at a negedge: drives the request, holds it until the done pulse, then watches for
    // stray pulses. gaps counts busy-low cycles before the pulse, busy during it, extra pulses.
    task automatic run_txn(input int kind, input logic [31:0] addr, input logic [1:0] len,
                           input logic [31:0] wd, output logic [31:0] rd, output int lat,
                           output int gaps);
        logic en, bsy;
        wlog.delete();
        inst_read_in    = (kind == 0);
        data_read_in    = (kind == 1);
        data_write_in   = (kind == 2);
        inst_address_in = addr;
        data_address_in = addr;
        data_len_in     = len;
        data_wdata_in   = wd;
        lat  = -1;
        rd   = 32'd0;
        gaps = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk_in);
            en  = (kind == 0) ? inst_enable_out : data_enable_out;
            bsy = (kind == 0) ? inst_busy_out : data_busy_out;
            if (en) begin
                lat = n;
                rd  = (kind == 0) ? inst_data_out : data_rdata_out;
                if (bsy) gaps++;
                break;
            end
            if (!bsy) gaps++;
        end
        inst_read_in  = 1'b0;
        data_read_in  = 1'b0;
        data_write_in = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk_in);
            if (inst_enable_out || data_enable_out) gaps++;
        end
    endtask

    task automatic apply(input string name, input vec_t v, input bit use_model);
        logic [31:0] rd, exp;
        int lat, gaps, n;
        n   = nbytes(v.kind, v.len);
        exp = use_model ? model_load(v.addr, n) : v.exp_rd;
        run_txn(v.kind, v.addr, v.len, v.wd, rd, lat, gaps);
        check({name, "_latency"}, 32'(lat), 32'(v.exp_lat));
        check({name, "_busy"}, 32'(gaps), 32'd0);
        if (v.kind == 2) begin
            model_store(v.addr, n, v.wd);
            check_wlog(name, v.addr, n, v.wd);
        end else begin
            check({name, "_data"}, rd, exp);
        end
    endtask

    initial begin
        vec_t vecs[$];
        logic [31:0] rd;
        int lat, gaps, d0, got_d, got_i, order_bad, en_seen;
        logic [31:0] drd, ird;

        for (int i = 0; i < 262144; i++) ram[i] = 8'd0;
        ram[18'h100] = 8'h13; ram[18'h101] = 8'h05; ram[18'h102] = 8'h00; ram[18'h103] = 8'h00;
        ram[18'h104] = 8'h93; ram[18'h105] = 8'h05; ram[18'h106] = 8'h10; ram[18'h107] = 8'h00;
        ram[18'h200] = 8'hA5; ram[18'h201] = 8'h5A;
        ram[18'h3FFFE] = 8'h11; ram[18'h3FFFF] = 8'h22; ram[18'h0] = 8'h33; ram[18'h1] = 8'h44;
        for (int i = 0; i < 16384; i++) ram[18'h10000 + 18'(i)] = 8'($urandom);
        for (int i = 0; i < 262144; i++) ref_mem[i] = ram[i];

        fork
            forever begin
                @(posedge clk_in);
                mem_din <= ram[mem_a[17:0]];
                if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
            end
            forever begin
                @(negedge clk_in);
                if (mem_wr) wlog.push_back({mem_a, mem_dout});
                if (mem_wr && !data_busy_out) wr_outside++;
                if (inst_enable_out) inst_pulses++;
                if (data_enable_out) data_pulses++;
            end
        join_none

        vecs.push_back('{0, 32'h100,      2'd3, 32'h0,        32'h00000513, 6});
        vecs.push_back('{1, 32'h200,      2'd0, 32'h0,        32'h000000A5, 3});
        vecs.push_back('{1, 32'h200,      2'd1, 32'h0,        32'h00005AA5, 4});
        vecs.push_back('{1, 32'h100,      2'd2, 32'h0,        32'h00000513, 6});
        vecs.push_back('{2, 32'h300,      2'd1, 32'h1234BEEF, 32'h0,        3});
        vecs.push_back('{1, 32'h300,      2'd3, 32'h0,        32'h0000BEEF, 6});
        vecs.push_back('{2, 32'h305,      2'd0, 32'hCAFEFF77, 32'h0,        2});
        vecs.push_back('{1, 32'h304,      2'd3, 32'h0,        32'h00007700, 6});
        vecs.push_back('{1, 32'hFFFFFFFE, 2'd3, 32'h0,        32'h44332211, 6});
        vecs.push_back('{2, 32'h310,      2'd2, 32'h87654321, 32'h0,        5});
        vecs.push_back('{1, 32'h310,      2'd3, 32'h0,        32'h87654321, 6});

        // Reset state.
        @(negedge clk_in);
        @(negedge clk_in);
        check("reset_flags", {27'd0, inst_busy_out, inst_enable_out, data_busy_out,
                              data_enable_out, mem_wr}, 32'd0);
        check("reset_inst_data", inst_data_out, 32'd0);
        check("reset_rdata", data_rdata_out, 32'd0);
        check("reset_mem_a", mem_a, 32'd0);
        check("reset_mem_dout", {24'd0, mem_dout}, 32'd0);
        rst_in = 1'b0;

        // First request goes in on the first edge after reset release.
        foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i], 1'b0);

        // Fetch and load contend in the same cycle: the load goes first.
        inst_read_in    = 1'b1;
        inst_address_in = 32'h100;
        data_read_in    = 1'b1;
        data_address_in = 32'h200;
        data_len_in     = 2'd0;
        got_d = 0; got_i = 0; order_bad = 0; drd = 32'd0; ird = 32'd0;
        for (int n = 0; n < 40 && !(got_d && got_i); n++) begin
            @(negedge clk_in);
            if (data_enable_out && got_d == 0) begin
                got_d = 1; drd = data_rdata_out; data_read_in = 1'b0;
                if (got_i != 0) order_bad = 1;
            end
            if (inst_enable_out && got_i == 0) begin
                got_i = 1; ird = inst_data_out; inst_read_in = 1'b0;
                if (got_d == 0) order_bad = 1;
            end
        end
        inst_read_in = 1'b0;
        data_read_in = 1'b0;
        check("contend_order", {29'd0, got_d[0], got_i[0], order_bad[0]}, 32'd6);
        check("contend_rdata", drd, 32'h000000A5);
        check("contend_inst", ird, 32'h00000513);
        repeat (3) @(negedge clk_in);

        // Branch flush while the fetch is at byte 2.
        inst_read_in    = 1'b1;
        inst_address_in = 32'h100;
        d0 = inst_pulses;
        repeat (3) @(negedge clk_in);
        jump_clear_in = 1'b1;
        inst_read_in  = 1'b0;
        @(negedge clk_in);
        check("jump_idle", {31'd0, inst_busy_out}, 32'd0);
        jump_clear_in = 1'b0;
        repeat (8) @(negedge clk_in);
        check("jump_no_pulse", 32'(inst_pulses - d0), 32'd0);
        run_txn(0, 32'h104, 2'd3, 32'd0, rd, lat, gaps);
        check("jump_refetch_data", rd, 32'h00100593);
        check("jump_refetch_lat", 32'(lat), 32'd6);

        // Reset in the middle of a word load.
        data_read_in    = 1'b1;
        data_address_in = 32'h100;
        data_len_in     = 2'd3;
        repeat (3) @(negedge clk_in);
        check("rst_mid_pre_busy", {31'd0, data_busy_out}, 32'd1);
        d0 = data_pulses;
        rst_in = 1'b1;
        #1;
        check("rst_mid_busy", {31'd0, data_busy_out}, 32'd0);
        check("rst_mid_mem_a", mem_a, 32'd0);
        data_read_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        run_txn(0, 32'h100, 2'd3, 32'd0, rd, lat, gaps);
        check("rst_mid_refetch_data", rd, 32'h00000513);
        check("rst_mid_refetch_lat", 32'(lat), 32'd6);
        check("rst_mid_no_data_pulse", 32'(data_pulses - d0), 32'd0);

`ifdef MEMCTRL_IO_STALL_EN
        // Byte store into the IO window with the UART buffer full for five cycles.
        wlog.delete();
        io_buffer_full  = 1'b1;
        data_write_in   = 1'b1;
        data_address_in = 32'h30000;
        data_len_in     = 2'd0;
        data_wdata_in   = 32'h0000005C;
        repeat (5) @(negedge clk_in);
        check("io_stall_no_wr", 32'(wlog.size()), 32'd0);
        @(posedge clk_in);
        #1;
        io_buffer_full = 1'b0;
        got_d = 0;
        for (int n = 0; n < 10 && got_d == 0; n++) begin
            @(negedge clk_in);
            if (data_enable_out) got_d = 1;
        end
        data_write_in = 1'b0;
        check("io_stall_done", 32'(got_d), 32'd1);
        model_store(32'h30000, 1, 32'h5C);
        check_wlog("io_stall", 32'h30000, 1, 32'h5C);
        repeat (3) @(negedge clk_in);
`else
        // Without the stall option a full UART buffer must not delay the store.
        io_buffer_full = 1'b1;
        run_txn(2, 32'h30000, 2'd0, 32'h5C, rd, lat, gaps);
        io_buffer_full = 1'b0;
        check("io_nostall_lat", 32'(lat), 32'd2);
        model_store(32'h30000, 1, 32'h5C);
        check_wlog("io_nostall", 32'h30000, 1, 32'h5C);
`endif

        // Random traffic against the reference memory.
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            int n;
            v.kind = int'($urandom_range(0, 2));
            v.len  = 2'($urandom_range(0, 3));
            v.addr = 32'($urandom_range(0, 32'h2FFF0));
            if (v.kind == 0) v.addr = v.addr & ~32'd3;
            v.wd     = $urandom;
            v.exp_rd = 32'd0;
            n = nbytes(v.kind, v.len);
            v.exp_lat = (v.kind == 2) ? n + 1 : n + 2;
            apply($sformatf("rand%0d", i), v, 1'b1);
        end

        check("mem_wr_outside_store", 32'(wr_outside), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk_in  input  1  system clock; all state updates on posedge.
REQ-002 rst_in  input  1  reset, asynchronous, active-high (`rst_enable`).
REQ-003 inst_read_in  input  1  instruction-fetch request from icache (held until served).
REQ-004 inst_address_in  input  32  instruction byte address, word-aligned.
REQ-005 inst_busy_out  output  1  instruction path occupied; icache must not raise a new request.
REQ-006 inst_enable_out  output  1  one-cycle pulse: inst_data_out valid.
REQ-007 inst_data_out  output  32  fetched word, little-endian assembled.
REQ-008 data_read_in / data_write_in  input  1 each  load/store request from LSB, mutually exclusive.
REQ-009 data_address_in  input  32  load/store byte address.
REQ-010 data_len_in  input  2  bytes minus one: 0 = byte, 1 = half, 3 = word; value 2 illegal.
REQ-011 data_wdata_in  input  32  store data, low bytes used.
REQ-012 data_busy_out / data_enable_out  output  1 each  data path occupied / one-cycle done pulse.
REQ-013 data_rdata_out  output  32  load result, zero-extended; sign extension belongs to LSB.
REQ-014 jump_clear_in  input  1  branch flush; aborts an in-flight instruction fetch.
REQ-015 io_buffer_full  input  1  UART output buffer full.
REQ-016 mem_din  input  8  RAM read byte, valid one cycle after mem_a.
REQ-017 mem_dout / mem_a / mem_wr  output  8 / 32 / 1  RAM write byte, address, write strobe (1 = write).

Function
REQ-018 States: IDLE, INST_READ, DATA_READ, DATA_WRITE; byte counter cnt 0..4.
REQ-019 IDLE: data request takes priority over instruction request when both sampled high.
REQ-020 On acceptance, latch address, length and wdata; assert the matching busy_out from the next cycle until the done pulse.
REQ-021 Reads: cycle i (i = 0..len) drives mem_a = base+i, mem_wr = 0; byte from cycle i is captured next cycle into bits [8i+7:8i].
REQ-022 Word read latency: request sampled at edge T -> enable pulse in cycle T+6; half T+4; byte T+3.
REQ-023 Writes: cycle i drives mem_a = base+i, mem_dout = wdata[8i+7:8i], mem_wr = 1; data_enable_out pulses the cycle after the last byte.
REQ-024 mem_wr is 1 only during DATA_WRITE byte cycles, 0 at all other times.
REQ-025 Done pulse: enable_out high for exactly one cycle, data outputs hold the value that cycle, busy drops the same cycle, FSM returns to IDLE.
REQ-026 A new request may be accepted in the cycle after the done pulse; no back-to-back overlap.
REQ-027 jump_clear_in high in INST_READ or IDLE: fetch discarded, no inst_enable_out pulse, IDLE next cycle.
REQ-028 jump_clear_in has no effect on DATA_READ/DATA_WRITE.
REQ-029 data_len_in = 2 treated as word (4 bytes).
REQ-030 Address arithmetic is 32-bit modulo 2^32; wrap at 0xFFFFFFFF is not special-cased.

Reset
REQ-031 rst_in high asynchronously forces IDLE, cnt = 0, all outputs 0, and discards any in-flight transfer.
REQ-032 First request is accepted on the first posedge after rst_in deasserts.

Configuration
REQ-033 MEMCTRL_IO_STALL_EN defined: DATA_WRITE byte cycles to addresses with a[17:16] = 2'b11 are held (mem_wr = 0, cnt frozen) while io_buffer_full = 1, and resume when it clears.
REQ-034 MEMCTRL_IO_STALL_EN undefined: io_buffer_full is ignored and writes never stall.

Structure
REQ-035 State encodings, length codes and the IO address constant are defined in Defines.v alongside the existing bus-width macros.
REQ-036 Single module; no sub-module is warranted.

Verification
REQ-037 Word fetch: RAM[0x100..0x103] = 13,05,00,00; inst_read at 0x100 -> inst_data_out = 0x00000513 pulsed at T+6, busy high in between.
REQ-038 Contention: inst_read and data_read(0x200, len 0) in the same cycle -> data served first (rdata = RAM[0x200]), fetch completes afterwards.
REQ-039 Store half 0xBEEF to 0x300 -> mem_wr cycles write EF to 0x300 and BE to 0x301; data_enable_out pulses once.
REQ-040 jump_clear_in pulsed at cnt = 2 of a fetch -> no inst_enable_out, IDLE next cycle, next fetch correct.
REQ-041 With MEMCTRL_IO_STALL_EN: byte store to 0x30000 while io_buffer_full = 1 for 5 cycles -> mem_wr stays 0 for those cycles, then one write.
REQ-042 rst_in asserted mid word-read -> outputs 0 immediately, no done pulse, a clean fetch succeeds after release.
